fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 192 +++++++++++++++++++
 tb/tb_fetch_unit.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch front end. Issues word fetches to an in-order
//   instruction memory and keeps at most two words in flight or buffered.
//   Returned words are held in a 2-entry queue and presented to decode.
//   Taken branches/jumps (PCSrc) redirect the fetch PC to pc_out + immExt,
//   flush the queue and drop any responses still outstanding.
//
// Parameters
//   RESET_PC    first fetch address after reset
//   NOP_INSTR   value on instruction while nothing valid is presented
//
// Ports
//   clk          clock, rising edge
//   reset        synchronous, active-low reset
//   imem_req     fetch request valid
//   imem_addr    word-aligned fetch address (current fetch PC)
//   imem_ready   memory accepts the request this cycle
//   imem_rvalid  in-order response valid
//   imem_rdata   response instruction word
//   stall        decode is not accepting this cycle
//   PCSrc        redirect for the presented instruction
//   immExt       extended immediate of the presented instruction
//   instruction  head instruction (NOP_INSTR when empty)
//   pc_out       PC of head instruction (last presented PC when empty)
//   inst_valid   instruction/pc_out valid
//   fetch_fault  misaligned redirect trap (only with FETCH_MISALIGN_TRAP_EN)
//
// Build option
//   FETCH_MISALIGN_TRAP_EN: a redirect target with bits[1:0] != 0 halts
//   fetching and raises fetch_fault until reset. When undefined the port
//   does not exist and target bits[1:0] are cleared.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        PCSrc,
  input  logic [31:0] immExt,
  output logic [31:0] instruction,
  output logic [31:0] pc_out,
  output logic        inst_valid
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic        fetch_fault
`endif
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  state_t      r_state, w_state_next;
  logic [31:0] r_fpc, w_fpc_next;
  logic [31:0] r_q_pc    [2];
  logic [31:0] r_q_instr [2];
  logic        r_q_head, w_q_head_next;
  logic [1:0]  r_q_count, w_q_count_next;
  logic [1:0]  r_inflight, w_inflight_next;
  logic [1:0]  r_discard, w_discard_next;
  logic [31:0] r_last_pc;

  logic        w_accept, w_resp, w_redirect, w_pop, w_push, w_trap;
  logic [31:0] w_target, w_target_eff, w_resp_pc;
  logic [1:0]  w_pend;
  logic [2:0]  w_occupancy;
  logic        w_wr_idx;
  logic [1:0]  w_wr_en;

  // Presentation of the queue head.
  assign inst_valid  = (r_q_count != 2'd0);
  assign instruction = inst_valid ? r_q_instr[r_q_head] : NOP_INSTR;
  assign pc_out      = inst_valid ? r_q_pc[r_q_head]    : r_last_pc;

  // Buffered plus outstanding words never exceed two.
  assign w_occupancy = {1'b0, r_q_count} + {1'b0, r_inflight};
  assign w_redirect  = inst_valid & PCSrc;

  // Gated by the reset input so nothing is accepted while reset is held;
  // no request in a redirect cycle because r_fpc is stale there.
  assign imem_req  = reset & (r_state != ST_HALT) & (w_occupancy < 3'd2) & ~w_redirect;
  assign imem_addr = r_fpc;

  assign w_accept = imem_req & imem_ready;
  assign w_resp   = imem_rvalid & (r_inflight != 2'd0);
  assign w_pop    = inst_valid & ~stall & ~PCSrc;
  assign w_push   = w_resp & (r_discard == 2'd0) & ~w_redirect;

  // Non-discarded outstanding requests were issued contiguously ending at
  // r_fpc - 4, so the oldest of them (the one returning) is r_fpc - 4*pend.
  assign w_pend    = r_inflight - r_discard;
  assign w_resp_pc = r_fpc - {28'd0, w_pend, 2'b00};

  assign w_target = pc_out + immExt;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign w_trap       = (w_target[1:0] != 2'b00);
  assign w_target_eff = w_target;
  assign fetch_fault  = (r_state == ST_HALT);
`else
  assign w_trap       = 1'b0;
  assign w_target_eff = w_target & ~32'h3;
`endif

  assign w_inflight_next = r_inflight + {1'b0, w_accept} - {1'b0, w_resp};

  // Tail slot: head when empty, the other slot when one entry is held.
  assign w_wr_idx = r_q_head ^ r_q_count[0];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_wr_en
      assign w_wr_en[gi] = w_push & (w_wr_idx == 1'(gi));
    end
  endgenerate

  always_comb begin
    w_state_next   = r_state;
    w_fpc_next     = r_fpc;
    w_discard_next = r_discard;
    w_q_count_next = r_q_count;
    w_q_head_next  = r_q_head;
    if (w_redirect) begin
      w_fpc_next     = w_target_eff;
      // Everything still outstanding after this cycle belongs to the
      // abandoned path, including a response that returns right now.
      w_discard_next = w_inflight_next;
      w_q_count_next = 2'd0;
      if (w_trap) begin
        w_state_next = ST_HALT;
      end else if (w_inflight_next != 2'd0) begin
        w_state_next = ST_FLUSH;
      end else begin
        w_state_next = ST_RUN;
      end
    end else begin
      if (w_accept) begin
        w_fpc_next = r_fpc + 32'd4;
      end
      if (w_resp && (r_discard != 2'd0)) begin
        w_discard_next = r_discard - 2'd1;
      end
      w_q_count_next = r_q_count + {1'b0, w_push} - {1'b0, w_pop};
      if (w_pop) begin
        w_q_head_next = ~r_q_head;
      end
      if (r_state != ST_HALT) begin
        w_state_next = (w_discard_next != 2'd0) ? ST_FLUSH : ST_RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= ST_RUN;
      r_fpc      <= RESET_PC;
      r_q_head   <= 1'b0;
      r_q_count  <= 2'd0;
      r_inflight <= 2'd0;
      r_discard  <= 2'd0;
      r_last_pc  <= RESET_PC;
    end else begin
      r_state    <= w_state_next;
      r_fpc      <= w_fpc_next;
      r_q_head   <= w_q_head_next;
      r_q_count  <= w_q_count_next;
      r_inflight <= w_inflight_next;
      r_discard  <= w_discard_next;
      r_last_pc  <= pc_out;
    end
  end

  // Queue storage needs no reset: entries are only read when counted valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (w_wr_en[i]) begin
        r_q_pc[i]    <= w_resp_pc;
        r_q_instr[i] <= imem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk, reset, imem_req, imem_ready, imem_rvalid, stall, PCSrc, inst_valid;
  logic [31:0] imem_addr, imem_rdata, immExt, instruction, pc_out;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        fetch_fault;
`endif

  fetch_unit #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .PCSrc       (PCSrc),
    .immExt      (immExt),
    .instruction (instruction),
    .pc_out      (pc_out),
    .inst_valid  (inst_valid)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .fetch_fault (fetch_fault)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  // Memory: in-order list of accepted addresses with the cycle each returns.
  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;
  mreq_t mem_q[$];
  int    mem_lat      = 1;
  int    last_due     = 0;
  bit    mem_jitter   = 0;
  bit    slow_c       = 0;
  bit    stray_en     = 0;
  bit    inject_stray = 0;

  // Architectural reference: next PC decode must see, next address to fetch.
  logic [31:0] exp_pc   = RESET_PC;
  logic [31:0] exp_req  = RESET_PC;
  logic [31:0] last_pc  = RESET_PC;
  int          outstanding = 0;
  bit          halted   = 0;
  int          pops     = 0;
  bit          found;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%08h expected=%08h cycle=%0d", tag, got, exp, cyc);
    end
  endtask

  task automatic do_cycle();
    logic [31:0] tgt;
    bit          redir;
    mreq_t       m;
    int          d;
    // memory response for this cycle
    if (!reset) begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end else if (inject_stray) begin
      imem_rvalid  = 1'b1;
      imem_rdata   = 32'hBAD0_0000 ^ 32'(cyc);
      inject_stray = 1'b0;
    end else if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = word_at(mem_q[0].addr);
      mem_q.delete(0);
    end else if (stray_en && mem_q.size() == 0 && outstanding == 0 && $urandom_range(0, 4) == 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hBAD1_0000 ^ 32'(cyc);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    #1;
    if (!reset) begin
      check_eq("req_in_reset", 32'(imem_req), 32'd0);
      mem_q.delete();
      inject_stray = 1'b1;   // stale response lands right after release
      outstanding  = 0;
      exp_pc       = RESET_PC;
      exp_req      = RESET_PC;
      last_pc      = RESET_PC;
      halted       = 1'b0;
      $display("reset cycle=%0d", cyc);
    end else begin
      redir = inst_valid && PCSrc;
      if (inst_valid) begin
        check_eq("pc_out", pc_out, exp_pc);
        check_eq("instruction", instruction, word_at(pc_out));
        last_pc = pc_out;
      end else begin
        check_eq("nop_when_empty", instruction, NOP);
        check_eq("pc_hold", pc_out, last_pc);
      end
      if (halted) check_eq("valid_halted", 32'(inst_valid), 32'd0);
      if (halted || redir) begin
        check_eq("req_blocked", 32'(imem_req), 32'd0);
      end else if (imem_req) begin
        check_eq("req_addr", imem_addr, exp_req);
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      check_eq("fetch_fault", 32'(fetch_fault), 32'(halted));
`endif
      if (imem_rvalid && outstanding > 0) outstanding--;
      if (imem_req && imem_ready) begin
        d = cyc + mem_lat + (mem_jitter ? int'($urandom_range(0, 3)) : 0)
            + ((slow_c && imem_addr == 32'hC) ? 3 : 0);
        if (d < last_due) d = last_due;
        last_due = d;
        m.addr = imem_addr;
        m.due  = d;
        mem_q.push_back(m);
        outstanding++;
        exp_req = exp_req + 32'd4;
        if (outstanding > 2) check_eq("inflight_limit", 32'(outstanding), 32'd2);
      end
      if (redir) begin
        tgt = pc_out + immExt;
`ifdef FETCH_MISALIGN_TRAP_EN
        if (tgt[1:0] != 2'b00) halted = 1'b1;
`else
        tgt[1:0] = 2'b00;
`endif
        exp_pc  = tgt;
        exp_req = tgt;
        $display("redirect pc=%08h target=%08h cycle=%0d", pc_out, tgt, cyc);
      end else if (inst_valid && !stall) begin
        exp_pc = exp_pc + 32'd4;
        pops++;
        $display("decode pc=%08h instr=%08h cycle=%0d", pc_out, instruction, cyc);
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
    stall = 1'b0; PCSrc = 1'b0; immExt = '0;
    @(negedge clk);
    repeat (3) do_cycle();

    // reset state
    check_eq("rst_valid", 32'(inst_valid), 32'd0);
    check_eq("rst_instr", instruction, NOP);
    check_eq("rst_pc_out", pc_out, RESET_PC);
    check_eq("rst_addr", imem_addr, RESET_PC);
    check_eq("rst_req", 32'(imem_req), 32'd0);

    // streaming with 1-cycle memory: request at release, data visible 2 cycles on
    reset = 1'b1;
    #1;
    check_eq("first_req", 32'(imem_req), 32'd1);
    check_eq("first_addr", imem_addr, RESET_PC);
    do_cycle();
    check_eq("c1_valid", 32'(inst_valid), 32'd0);
    do_cycle();
    check_eq("c2_valid", 32'(inst_valid), 32'd1);
    check_eq("c2_pc", pc_out, RESET_PC);
    repeat (12) do_cycle();

    // decode stall: queue fills, requests stop
    stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k == 4) begin
        check_eq("stall_req_off", 32'(imem_req), 32'd0);
        check_eq("stall_head_valid", 32'(inst_valid), 32'd1);
      end
      do_cycle();
    end
    stall = 1'b0;
    repeat (8) do_cycle();

    // memory not ready: request and address held
    imem_ready = 1'b0;
    for (int k = 0; k < 10 && !imem_req; k++) do_cycle();
    check_eq("busy_req_wait", 32'(imem_req), 32'd1);
    begin
      logic [31:0] held;
      held = imem_addr;
      for (int k = 0; k < 3; k++) begin
        do_cycle();
        check_eq("busy_req_held", 32'(imem_req), 32'd1);
        check_eq("busy_addr_held", imem_addr, held);
      end
    end
    imem_ready = 1'b1;
    repeat (6) do_cycle();

    // reset mid-stream with a response outstanding
    mem_lat = 2;
    for (int k = 0; k < 10 && outstanding == 0; k++) do_cycle();
    reset = 1'b0;
    do_cycle();
    reset = 1'b1;
    #1;
    check_eq("mid_rst_valid", 32'(inst_valid), 32'd0);
    check_eq("mid_rst_instr", instruction, NOP);
    check_eq("mid_rst_pc", pc_out, RESET_PC);
    check_eq("mid_rst_req", 32'(imem_req), 32'd1);
    check_eq("mid_rst_addr", imem_addr, RESET_PC);

    // redirect at pc 0x8 with the fetch of 0xC still outstanding
    slow_c = 1'b1;
    found  = 1'b0;
    for (int k = 0; k < 60 && !found; k++) begin
      if (inst_valid && pc_out == 32'h8) begin
        PCSrc  = 1'b1;
        immExt = 32'h100;
        found  = 1'b1;
      end
      do_cycle();
      PCSrc = 1'b0;
    end
    check_eq("redir_seen", 32'(found), 32'd1);
    for (int k = 0; k < 40 && !inst_valid; k++) do_cycle();
    check_eq("redir_valid", 32'(inst_valid), 32'd1);
    check_eq("redir_pc", pc_out, 32'h108);
    slow_c = 1'b0;

    // misaligned redirect target 0x102
    for (int k = 0; k < 40 && !inst_valid; k++) do_cycle();
    check_eq("mis_head_valid", 32'(inst_valid), 32'd1);
    PCSrc  = 1'b1;
    immExt = 32'h102 - pc_out;
    do_cycle();
    PCSrc  = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    for (int k = 0; k < 5; k++) begin
      check_eq("trap_fault", 32'(fetch_fault), 32'd1);
      check_eq("trap_req", 32'(imem_req), 32'd0);
      do_cycle();
    end
    reset = 1'b0;
    do_cycle();
    reset = 1'b1;
`else
    for (int k = 0; k < 10 && !imem_req; k++) do_cycle();
    check_eq("mis_req", 32'(imem_req), 32'd1);
    check_eq("mis_addr", imem_addr, 32'h100);
`endif
    repeat (10) do_cycle();

    // randomized traffic
    mem_lat    = 1;
    mem_jitter = 1'b1;
    stray_en   = 1'b1;
    for (int k = 0; k < 1500; k++) begin
      imem_ready = ($urandom_range(0, 3) != 0);
      stall      = ($urandom_range(0, 3) == 0);
      PCSrc      = ($urandom_range(0, 9) == 0);
`ifdef FETCH_MISALIGN_TRAP_EN
      immExt = ($urandom_range(0, 63) << 2) - 32'd128;
`else
      immExt = $urandom_range(0, 255) - 32'd128;
`endif
      reset = ($urandom_range(0, 299) != 0);
      do_cycle();
    end
    reset = 1'b1; PCSrc = 1'b0; stall = 1'b0; imem_ready = 1'b1;
    repeat (10) do_cycle();

    check_eq("progress", 32'(pops >= 100), 32'd1);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
